datapath_core: RTL and testbench
================================

// Module: datapath_core
// PURPOSE
//  16-bit multicycle CPU datapath slice: instruction register (IR), 16x16 register
//  file, immediate generator and registered ALU. Control unit drives the selects;
//  memory and PC logic sit outside this block. Operand fields decode from the IR.
// PARAMETERS
//  none (data width fixed at 16, register count fixed at 16)
// PORTS
//  CLK          in   1   single clock; all state updates on rising edge
//  reset        in   1   asynchronous, active-low; clears all state
//  instruction  in   16  instruction word from memory
//  IRWrite      in   1   load instruction into IR
//  regWrite     in   1   write dataWrite into register rd
//  dataWrite    in   16  register file write data
//  DOrS         in   1   0: rs0 = IR[7:4]; 1: rs0 = IR[11:8] (rd)
//  ALUSrcA      in   1   0: ALU A = PC; 1: ALU A = regfile port A
//  ALUSrcB      in   1   0: ALU B = regfile port B; 1: ALU B = immGen
//  ALUOp        in   3   ALU operation (see BEHAVIOUR)
//  numBits      in   2   immediate field width select
//  immShift     in   2   immediate left shift, in nibbles
//  PC           in   16  program counter value
//  ir           out  16  IR contents
//  A            out  16  regfile read port 0 (R[rs0])
//  B            out  16  regfile read port 1 (R[rs1])
//  immGen       out  16  generated immediate (combinational)
//  ALUOut       out  16  registered ALU result
//  zero         out  1   1 when ALUOut == 0
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): IR=0, all 16 registers=0, ALUOut=0. Held until reset=1.
//  - IR: on posedge with IRWrite=1, IR <= instruction; otherwise IR holds.
//  - Decode from IR: rd=IR[11:8], rs0=DOrS?IR[11:8]:IR[7:4], rs1=IR[3:0], din=IR[11:0].
//  - Regfile: two combinational read ports; one write port on posedge when regWrite=1.
//    All 16 registers writable (no hardwired zero). No write-to-read bypass: a written
//    value appears on A/B only after the edge.
//  - Simultaneous IRWrite and regWrite: write uses rd decoded from the old IR.
//  - immGen: field = numBits 00: din[3:0]; 01: din[7:0]; 10: din[11:0]; 11: din[7:0]
//    zero-extended. Codes 00/01/10 sign-extend to 16 bits. Result is then shifted left
//    by 4*immShift bits, truncated to 16 bits, with zero fill.
//  - ALU operands: X = ALUSrcA ? A : PC; Y = ALUSrcB ? immGen : B.
//  - ALUOp: 000 X+Y; 001 X-Y; 010 X&Y; 011 X|Y; 100 X^Y; 101 X<<Y[3:0];
//    110 X>>>Y[3:0] (arithmetic); 111 (signed X<signed Y)?1:0.
//    Add/sub wrap modulo 2^16; no carry or overflow outputs.
//  - ALUOut <= ALU result on every posedge, one cycle of latency, no enable.
//    zero is derived from the registered ALUOut.
//  - Outputs A, B and immGen are combinational from IR and regfile state.
// TESTING
//  1 reset=0 mid-operation -> ir=0, ALUOut=0, zero=1; after release, all A/B reads 0.
//  2 Load IR=0x0300; regWrite=1, dataWrite=0x1234, one edge; then IR=0x0030 -> A=0x1234.
//    With DOrS=1 and IR=0x0300 -> A=0x1234.
//  3 R1=5, R2=7, IR=0x0012, ALUSrcA=1, ALUSrcB=0, ALUOp=000 -> ALUOut=0x000C after 1 edge.
//    ALUOp=001 -> 0xFFFE; ALUOp=111 -> 0x0001.
//  4 IR=0x0008: numBits=00, immShift=0 -> immGen=0xFFF8; immShift=1 -> 0xFF80.
//    IR=0x0F80 with numBits=11 -> 0x0080.
//  5 PC=0x0010, ALUSrcA=0, ALUSrcB=1, immGen=2 (IR=0x0002, numBits=00), ALUOp=000 -> ALUOut=0x0012.
//  6 IRWrite=1 and regWrite=1 on the same edge -> write lands in rd of the old IR;
//    write-then-read in the same cycle returns the old value.

Source files
------------

// File: rtl/datapath_core_if.sv
// rtl/datapath_core_if.sv - control, data and observation signals of the datapath slice
interface datapath_core_if;
  logic [15:0] instruction;
  logic        IRWrite;
  logic        regWrite;
  logic [15:0] dataWrite;
  logic        DOrS;
  logic        ALUSrcA;
  logic        ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  numBits;
  logic [1:0]  immShift;
  logic [15:0] PC;
  logic [15:0] ir;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] immGen;
  logic [15:0] ALUOut;
  logic        zero;

  // Control unit / memory side drives selects and data, observes datapath state
  modport master (
    output instruction, IRWrite, regWrite, dataWrite, DOrS, ALUSrcA, ALUSrcB,
    output ALUOp, numBits, immShift, PC,
    input  ir, A, B, immGen, ALUOut, zero
  );

  // Datapath side
  modport slave (
    input  instruction, IRWrite, regWrite, dataWrite, DOrS, ALUSrcA, ALUSrcB,
    input  ALUOp, numBits, immShift, PC,
    output ir, A, B, immGen, ALUOut, zero
  );
endinterface

// File: rtl/datapath_core.sv
// rtl/datapath_core.sv - 16-bit multicycle datapath slice: IR, 16x16 regfile, immediate generator, registered ALU
module datapath_core (
  input  logic              CLK,
  input  logic              reset,
  datapath_core_if.slave    bus
);

  logic [15:0] ir_q;
  logic [15:0] rf_q [16];
  logic [15:0] alu_out_q;
  logic [15:0] alu_d;

  logic [3:0]  rd;
  logic [3:0]  rs0;
  logic [3:0]  rs1;
  logic [11:0] din;
  logic [15:0] imm_field;
  logic [15:0] imm_val;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic [15:0] op_x;
  logic [15:0] op_y;

  // Operand fields come from the current IR; the write target uses the IR held before any load on the same edge
  assign rd   = ir_q[11:8];
  assign rs0  = bus.DOrS ? ir_q[11:8] : ir_q[7:4];
  assign rs1  = ir_q[3:0];
  assign din  = ir_q[11:0];

  assign rd_a = rf_q[rs0];
  assign rd_b = rf_q[rs1];

  // Select and extend the immediate field; code 11 is the only zero-extended form
  always_comb begin
    imm_field = '0;
    case (bus.numBits)
      2'b00:   imm_field = {{12{din[3]}}, din[3:0]};
      2'b01:   imm_field = {{8{din[7]}}, din[7:0]};
      2'b10:   imm_field = {{4{din[11]}}, din[11:0]};
      default: imm_field = {8'h00, din[7:0]};
    endcase
  end

  assign imm_val = imm_field << {bus.immShift, 2'b00};

  assign op_x = bus.ALUSrcA ? rd_a : bus.PC;
  assign op_y = bus.ALUSrcB ? imm_val : rd_b;

  // ALU result computed every cycle; shifts use only the low nibble of Y
  always_comb begin
    alu_d = '0;
    case (bus.ALUOp)
      3'b000:  alu_d = op_x + op_y;
      3'b001:  alu_d = op_x - op_y;
      3'b010:  alu_d = op_x & op_y;
      3'b011:  alu_d = op_x | op_y;
      3'b100:  alu_d = op_x ^ op_y;
      3'b101:  alu_d = op_x << op_y[3:0];
      3'b110:  alu_d = $signed(op_x) >>> op_y[3:0];
      default: alu_d = {15'd0, ($signed(op_x) < $signed(op_y))};
    endcase
  end

  // IR load, regfile write and unconditional ALU result register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ir_q      <= '0;
      alu_out_q <= '0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      alu_out_q <= alu_d;
      if (bus.IRWrite) begin
        ir_q <= bus.instruction;
      end
      if (bus.regWrite) begin
        rf_q[rd] <= bus.dataWrite;
      end
    end
  end

  assign bus.ir     = ir_q;
  assign bus.A      = rd_a;
  assign bus.B      = rd_b;
  assign bus.immGen = imm_val;
  assign bus.ALUOut = alu_out_q;
  assign bus.zero   = (alu_out_q == 16'd0);

endmodule

// File: tb/tb_datapath_core.sv
// tb/tb_datapath_core.sv - randomized and directed bench for datapath_core against a behavioural model
module tb_datapath_core;

  logic CLK = 1'b0;
  logic reset;

  always #5 CLK = ~CLK;

  datapath_core_if bus ();

  datapath_core dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_ir;
  int m_rf [16];
  int m_alu;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  function automatic int to_signed16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int field_of(input int v, input int lsb, input int width);
    return (v / (1 << lsb)) % (1 << width);
  endfunction

  function automatic int model_imm();
    int v;
    case (int'(bus.numBits))
      0: begin v = field_of(m_ir, 0, 4);  if (v >= 8)    v -= 16;   end
      1: begin v = field_of(m_ir, 0, 8);  if (v >= 128)  v -= 256;  end
      2: begin v = field_of(m_ir, 0, 12); if (v >= 2048) v -= 4096; end
      default: v = field_of(m_ir, 0, 8);
    endcase
    v = v * (1 << (4 * int'(bus.immShift)));
    return ((v % 65536) + 65536) % 65536;
  endfunction

  function automatic int model_rs0();
    return bus.DOrS ? field_of(m_ir, 8, 4) : field_of(m_ir, 4, 4);
  endfunction

  function automatic int model_alu(input int x, input int y, input int op);
    int s;
    int sx;
    int r;
    s  = y % 16;
    sx = to_signed16(x);
    case (op)
      0: r = (x + y) % 65536;
      1: r = (x - y + 65536) % 65536;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = (x * (1 << s)) % 65536;
      6: begin
        if (sx >= 0) r = sx / (1 << s);
        else         r = -((-sx + (1 << s) - 1) / (1 << s));
        r = (r + 65536) % 65536;
      end
      default: r = (sx < to_signed16(y)) ? 1 : 0;
    endcase
    return r;
  endfunction

  task automatic model_clear();
    m_ir  = 0;
    m_alu = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
  endtask

  task automatic set_idle();
    bus.instruction = '0;
    bus.IRWrite     = 1'b0;
    bus.regWrite    = 1'b0;
    bus.dataWrite   = '0;
    bus.DOrS        = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 1'b0;
    bus.ALUOp       = '0;
    bus.numBits     = '0;
    bus.immShift    = '0;
    bus.PC          = '0;
  endtask

  // Check combinational outputs, clock once, advance the model, check registered outputs
  task automatic step();
    int x;
    int y;
    int res;
    int wr;
    #1;
    check("ir", bus.ir, 16'(m_ir));
    check("A", bus.A, 16'(m_rf[model_rs0()]));
    check("B", bus.B, 16'(m_rf[field_of(m_ir, 0, 4)]));
    check("immGen", bus.immGen, 16'(model_imm()));
    x   = bus.ALUSrcA ? m_rf[model_rs0()] : int'(bus.PC);
    y   = bus.ALUSrcB ? model_imm() : m_rf[field_of(m_ir, 0, 4)];
    res = model_alu(x, y, int'(bus.ALUOp));
    wr  = field_of(m_ir, 8, 4);
    @(posedge CLK);
    if (bus.regWrite) m_rf[wr] = int'(bus.dataWrite);
    if (bus.IRWrite)  m_ir = int'(bus.instruction);
    m_alu = res;
    #1;
    check("ALUOut", bus.ALUOut, 16'(m_alu));
    check("zero", 16'(bus.zero), (m_alu == 0) ? 16'd1 : 16'd0);
  endtask

  initial begin
    set_idle();
    model_clear();
    reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ir", bus.ir, 16'h0000);
    check("rst_alu", bus.ALUOut, 16'h0000);
    check("rst_zero", 16'(bus.zero), 16'h0001);
    reset = 1'b1;

    // IR/regfile write and readback through both rs0 selects
    bus.IRWrite = 1'b1; bus.instruction = 16'h0300; step();
    bus.IRWrite = 1'b0; bus.regWrite = 1'b1; bus.dataWrite = 16'h1234; step();
    bus.regWrite = 1'b0; bus.IRWrite = 1'b1; bus.instruction = 16'h0030; step();
    bus.IRWrite = 1'b0; #1;
    check("t2_A_rs0", bus.A, 16'h1234);
    bus.IRWrite = 1'b1; bus.instruction = 16'h0300; step();
    bus.IRWrite = 1'b0; bus.DOrS = 1'b1; #1;
    check("t2_A_rd", bus.A, 16'h1234);
    bus.DOrS = 1'b0;

    // R1=5 written while IR loads simultaneously (lands in old rd), then R2=7
    bus.IRWrite = 1'b1; bus.instruction = 16'h0100; step();
    bus.regWrite = 1'b1; bus.dataWrite = 16'h0005; bus.instruction = 16'h0200; step();
    bus.dataWrite = 16'h0007; bus.instruction = 16'h0012; step();
    bus.IRWrite = 1'b0; bus.regWrite = 1'b0; #1;
    check("t6_R1_old_rd", bus.A, 16'h0005);
    check("t6_R2", bus.B, 16'h0007);
    bus.ALUSrcA = 1'b1; bus.ALUSrcB = 1'b0; bus.ALUOp = 3'b000; step();
    check("t3_add", bus.ALUOut, 16'h000C);
    bus.ALUOp = 3'b001; step();
    check("t3_sub", bus.ALUOut, 16'hFFFE);
    bus.ALUOp = 3'b111; step();
    check("t3_slt", bus.ALUOut, 16'h0001);

    // Immediate generator boundaries
    bus.IRWrite = 1'b1; bus.instruction = 16'h0008; step();
    bus.IRWrite = 1'b0; bus.numBits = 2'b00; bus.immShift = 2'd0; #1;
    check("t4_imm_s0", bus.immGen, 16'hFFF8);
    step();
    bus.immShift = 2'd1; #1;
    check("t4_imm_s1", bus.immGen, 16'hFF80);
    bus.immShift = 2'd0; bus.IRWrite = 1'b1; bus.instruction = 16'h0F80; step();
    bus.IRWrite = 1'b0; bus.numBits = 2'b11; #1;
    check("t4_imm_zx", bus.immGen, 16'h0080);

    // PC + immediate
    bus.IRWrite = 1'b1; bus.instruction = 16'h0002; step();
    bus.IRWrite = 1'b0; bus.numBits = 2'b00; bus.PC = 16'h0010;
    bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b1; bus.ALUOp = 3'b000; step();
    check("t5_pc_imm", bus.ALUOut, 16'h0012);

    // Write then read in the same cycle sees the old value
    bus.IRWrite = 1'b1; bus.instruction = 16'h0533; step();
    bus.IRWrite = 1'b0; bus.DOrS = 1'b1; bus.regWrite = 1'b1; bus.dataWrite = 16'hBEEF; #1;
    check("t6_no_bypass", bus.A, 16'h0000);
    step();
    bus.regWrite = 1'b0; #1;
    check("t6_after_edge", bus.A, 16'hBEEF);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.instruction = 16'($urandom);
      bus.IRWrite     = ($urandom_range(0, 3) == 0);
      bus.regWrite    = ($urandom_range(0, 1) == 0);
      bus.dataWrite   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      bus.DOrS        = 1'($urandom);
      bus.ALUSrcA     = 1'($urandom);
      bus.ALUSrcB     = 1'($urandom);
      bus.ALUOp       = 3'($urandom);
      bus.numBits     = 2'($urandom);
      bus.immShift    = 2'($urandom);
      bus.PC          = 16'($urandom);
      step();
    end

    // Asynchronous reset in the middle of a cycle
    bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b0; bus.PC = 16'h00FF; bus.ALUOp = 3'b011;
    step();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ir", bus.ir, 16'h0000);
    check("mid_rst_alu", bus.ALUOut, 16'h0000);
    check("mid_rst_zero", 16'(bus.zero), 16'h0001);
    model_clear();
    set_idle();
    @(posedge CLK);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.IRWrite = 1'b1; bus.instruction = 16'(i * 17); step();
      bus.IRWrite = 1'b0; #1;
      check("rst_regA", bus.A, 16'h0000);
      check("rst_regB", bus.B, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
